// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade player-input front end: PS/2 keycodes,
// joystick word layout and the keyboard-code-to-target decoder.
package arcade_input_pkg;

  localparam logic [7:0] KEY_UP     = 8'h75;
  localparam logic [7:0] KEY_DOWN   = 8'h72;
  localparam logic [7:0] KEY_LEFT   = 8'h6B;
  localparam logic [7:0] KEY_RIGHT  = 8'h74;
  localparam logic [7:0] KEY_BTN0A  = 8'h14;
  localparam logic [7:0] KEY_BTN0B  = 8'h11;
  localparam logic [7:0] KEY_BTN1   = 8'h29;
  localparam logic [7:0] KEY_BTN2   = 8'h12;
  localparam logic [7:0] KEY_START0 = 8'h05;
  localparam logic [7:0] KEY_START1 = 8'h06;
  localparam logic [7:0] KEY_COIN0  = 8'h04;
  localparam logic [7:0] KEY_PAUSE  = 8'h0C;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_BTN0  = 4;

  typedef enum logic [3:0] {
    KT_NONE, KT_UP, KT_DOWN, KT_LEFT, KT_RIGHT, KT_BTN0, KT_BTN1, KT_BTN2,
    KT_START0, KT_START1, KT_COIN0, KT_PAUSE
  } key_tgt_e;

  // Joystick word: 4 directions, buttons, then start, coin, pause.
  function automatic int joy_w(input int nbuttons);
    return 7 + nbuttons;
  endfunction

  function automatic key_tgt_e key_target(input logic [7:0] code);
    case (code)
      KEY_UP:               return KT_UP;
      KEY_DOWN:             return KT_DOWN;
      KEY_LEFT:             return KT_LEFT;
      KEY_RIGHT:            return KT_RIGHT;
      KEY_BTN0A, KEY_BTN0B: return KT_BTN0;
      KEY_BTN1:             return KT_BTN1;
      KEY_BTN2:             return KT_BTN2;
      KEY_START0:           return KT_START0;
      KEY_START1:           return KT_START1;
      KEY_COIN0:            return KT_COIN0;
      KEY_PAUSE:            return KT_PAUSE;
      default:              return KT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arcade_pulse_stretch.sv
// Holds dout high while din is high and for CYCLES clocks after each rising
// edge of din; a new edge during a stretch restarts the count.
module arcade_pulse_stretch
  import arcade_input_pkg::*;
#(
  parameter int CNTW   = 20,
  parameter int CYCLES = 600000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic            din_q;
  logic [CNTW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= 1'b0;
      cnt   <= '0;
    end else begin
      din_q <= din;
      if (din && !din_q)
        cnt <= CNTW'(CYCLES);
      else if (cnt != '0)
        cnt <= cnt - CNTW'(1);
    end
  end

  assign dout = din || (cnt != '0);

endmodule

// File: rtl/arcade_input_ctrl.sv
// Player-input front end: merges PS/2 keyboard, HPS joysticks and JAMMA into
// per-player direction/button/start/coin vectors with autofire, coin stretch and pause.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int NPLAYERS    = 2,
  parameter int NBUTTONS    = 2,
  parameter int CNTW        = 20,
  parameter int COIN_CYCLES = 600000,
  parameter int AF_HALF     = 400000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [10:0]                      ps2_key,
  input  logic [NPLAYERS*joy_w(NBUTTONS)-1:0] joy_in,
  input  logic [NPLAYERS*4-1:0]            jamma_udlr,
  input  logic [NPLAYERS*NBUTTONS-1:0]     jamma_btn,
  input  logic [NPLAYERS-1:0]              jamma_start,
  input  logic [NPLAYERS-1:0]              jamma_coin,
  input  logic                             soft_rst,
  input  logic [NBUTTONS-1:0]              autofire_en,
  output logic [NPLAYERS*4-1:0]            p_dir,
  output logic [NPLAYERS*NBUTTONS-1:0]     p_btn,
  output logic [NPLAYERS-1:0]              start,
  output logic [NPLAYERS-1:0]              coin,
  output logic                             pause
);

  localparam int   JW        = joy_w(NBUTTONS);
  localparam int   NB        = NBUTTONS;
  localparam int   START_BIT = JOY_BTN0 + NB;
  localparam int   COIN_BIT  = JOY_BTN0 + NB + 1;
  localparam int   PAUSE_BIT = JOY_BTN0 + NB + 2;
  localparam int   S1        = (NPLAYERS > 1) ? 1 : 0;
  localparam logic POL       = (ACTIVE_LOW != 0);

  logic [NPLAYERS*JW-1:0]  joy_q;
  logic [NPLAYERS*4-1:0]   jamma_udlr_q;
  logic [NPLAYERS*NB-1:0]  jamma_btn_q;
  logic [NPLAYERS-1:0]     jamma_start_q, jamma_coin_q;
  logic                    soft_rst_q;
  logic [NB-1:0]           af_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      joy_q         <= '0;
      jamma_udlr_q  <= '0;
      jamma_btn_q   <= '0;
      jamma_start_q <= '0;
      jamma_coin_q  <= '0;
      soft_rst_q    <= 1'b0;
      af_en_q       <= '0;
    end else begin
      joy_q         <= joy_in;
      jamma_udlr_q  <= jamma_udlr;
      jamma_btn_q   <= jamma_btn;
      jamma_start_q <= jamma_start;
      jamma_coin_q  <= jamma_coin;
      soft_rst_q    <= soft_rst;
      af_en_q       <= autofire_en;
    end
  end

  // Keyboard latches live in player 0's joystick layout; start1 is separate.
  logic          tog_q, ps2_event, unused_ext;
  logic [JW-1:0] key_p0, key_next;
  logic          key_start1, key_start1_next;

  assign ps2_event  = ps2_key[10] ^ tog_q;
  assign unused_ext = ps2_key[8];

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    key_next        = key_p0;
    key_start1_next = key_start1;
    if (ps2_event) begin
      unique case (key_target(ps2_key[7:0]))
        KT_UP:     key_next[JOY_UP]    = ps2_key[9];
        KT_DOWN:   key_next[JOY_DOWN]  = ps2_key[9];
        KT_LEFT:   key_next[JOY_LEFT]  = ps2_key[9];
        KT_RIGHT:  key_next[JOY_RIGHT] = ps2_key[9];
        KT_BTN0:   key_next[JOY_BTN0]  = ps2_key[9];
        KT_BTN1:   if (NB > 1) key_next[JOY_BTN0 + 1] = ps2_key[9];
        KT_BTN2:   if (NB > 2) key_next[JOY_BTN0 + 2] = ps2_key[9];
        KT_START0: key_next[START_BIT] = ps2_key[9];
        KT_START1: if (NPLAYERS > 1) key_start1_next = ps2_key[9];
        KT_COIN0:  key_next[COIN_BIT]  = ps2_key[9];
        KT_PAUSE:  key_next[PAUSE_BIT] = ps2_key[9];
        default:   ;
      endcase
    end
  end

  // The toggle copy follows the port even in reset, so leaving reset never
  // looks like a keyboard event.
  always_ff @(posedge clk) begin
    tog_q <= ps2_key[10];
    if (rst) begin
      key_p0     <= '0;
      key_start1 <= 1'b0;
    end else begin
      key_p0     <= key_next;
      key_start1 <= key_start1_next;
    end
  end

  logic [NPLAYERS*JW-1:0] key_all;
  logic [NPLAYERS-1:0]    key_start_all;

  always_comb begin
    key_all             = '0;
    key_all[JW-1:0]     = key_p0;
    key_start_all       = '0;
    key_start_all[S1]   = key_start1;
  end

  // Autofire phase: free-running half-period counter, phase starts high.
  logic [CNTW-1:0] af_cnt;
  logic            phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      af_cnt <= '0;
      phase  <= 1'b1;
    end else if (af_cnt == CNTW'(AF_HALF - 1)) begin
      af_cnt <= '0;
      phase  <= ~phase;
    end else begin
      af_cnt <= af_cnt + CNTW'(1);
    end
  end

  logic [NPLAYERS*4-1:0]  raw_dir;
  logic [NPLAYERS*NB-1:0] raw_btn, btn_af;
  logic [NPLAYERS-1:0]    raw_start, raw_coin, coin_str, pause_src;

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
    logic [JW-1:0] rj;
    assign rj = joy_q[p*JW +: JW] | key_all[p*JW +: JW];

    assign raw_dir[p*4 +: 4]   = rj[3:0] | jamma_udlr_q[p*4 +: 4];
    assign raw_btn[p*NB +: NB] = rj[JOY_BTN0 +: NB] | jamma_btn_q[p*NB +: NB];
    assign raw_start[p]        = rj[START_BIT] | jamma_start_q[p] | key_start_all[p];
    assign raw_coin[p]         = rj[COIN_BIT] | jamma_coin_q[p];
    assign pause_src[p]        = rj[PAUSE_BIT];

    arcade_pulse_stretch #(.CNTW(CNTW), .CYCLES(COIN_CYCLES)) u_coin (
      .clk  (clk),
      .rst  (rst),
      .din  (raw_coin[p]),
      .dout (coin_str[p])
    );

    for (genvar b = 0; b < NB; b++) begin : g_btn
      assign btn_af[p*NB + b] = raw_btn[p*NB + b] & (~af_en_q[b] | phase);
    end
  end

  // Pause toggles on a rising edge of any pause source; soft reset wins.
  logic pause_any, pause_src_q;
  assign pause_any = |pause_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      pause_src_q <= 1'b0;
      pause       <= 1'b0;
    end else begin
      pause_src_q <= pause_any;
      if (soft_rst_q)
        pause <= 1'b0;
      else if (pause_any && !pause_src_q)
        pause <= ~pause;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_dir <= {(NPLAYERS*4){POL}};
      p_btn <= {(NPLAYERS*NB){POL}};
      start <= {NPLAYERS{POL}};
      coin  <= {NPLAYERS{POL}};
    end else begin
      p_dir <= raw_dir   ^ {(NPLAYERS*4){POL}};
      p_btn <= btn_af    ^ {(NPLAYERS*NB){POL}};
      start <= raw_start ^ {NPLAYERS{POL}};
      coin  <= coin_str  ^ {NPLAYERS{POL}};
    end
  end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Self-checking bench for arcade_input_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_arcade_input_ctrl;

  localparam int NP   = 2;
  localparam int NB   = 2;
  localparam int JW   = 7 + NB;
  localparam int COIN = 10;
  localparam int AF   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [10:0]       ps2_key;
  logic [NP*JW-1:0]  joy_in;
  logic [NP*4-1:0]   jamma_udlr;
  logic [NP*NB-1:0]  jamma_btn;
  logic [NP-1:0]     jamma_start, jamma_coin;
  logic              soft_rst;
  logic [NB-1:0]     autofire_en;
  logic [NP*4-1:0]   p_dir;
  logic [NP*NB-1:0]  p_btn;
  logic [NP-1:0]     start, coin;
  logic              pause;

  arcade_input_ctrl #(
    .NPLAYERS(NP), .NBUTTONS(NB), .CNTW(20), .COIN_CYCLES(COIN),
    .AF_HALF(AF), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .ps2_key(ps2_key), .joy_in(joy_in),
    .jamma_udlr(jamma_udlr), .jamma_btn(jamma_btn), .jamma_start(jamma_start),
    .jamma_coin(jamma_coin), .soft_rst(soft_rst), .autofire_en(autofire_en),
    .p_dir(p_dir), .p_btn(p_btn), .start(start), .coin(coin), .pause(pause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Keyboard targets: 0 up,1 down,2 left,3 right,4 btn0,5 btn1,6 btn2,
  // 7 start0,8 start1,9 coin0,10 pause.
  function automatic int tgt(input logic [7:0] c);
    case (c)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      8'h14, 8'h11: return 4;
      8'h29: return 5;
      8'h12: return (NB > 2) ? 6 : -1;
      8'h05: return 7;
      8'h06: return (NP > 1) ? 8 : -1;
      8'h04: return 9;
      8'h0C: return 10;
      default: return -1;
    endcase
  endfunction

  bit              m_valid = 0;
  bit              m_tog;
  bit              held [11];
  bit [NP*JW-1:0]  d_joy;
  bit [NP*4-1:0]   d_udlr;
  bit [NP*NB-1:0]  d_btn;
  bit [NP-1:0]     d_start, d_coin;
  bit              d_soft;
  bit [NB-1:0]     d_af;
  int              since [NP];
  bit              prev_coin [NP];
  int              k_edges;
  bit              m_pause, m_pause_prev, m_phase, m_psrc, m_r;
  bit [3:0]        m_dir4;
  bit [NP*4-1:0]   e_dir;
  bit [NP*NB-1:0]  e_btn;
  bit [NP-1:0]     e_start, e_coin;
  bit              e_pause;

  // Outputs at an edge come from the inputs sampled one edge earlier and from
  // the keyboard state as it stood before this edge.
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_tog   = ps2_key[10];
      foreach (held[i]) held[i] = 0;
      d_joy = '0; d_udlr = '0; d_btn = '0; d_start = '0; d_coin = '0;
      d_soft = 0; d_af = '0;
      for (int p = 0; p < NP; p++) begin since[p] = 1000; prev_coin[p] = 0; end
      k_edges = 0; m_pause = 0; m_pause_prev = 0;
      e_dir = '0; e_btn = '0; e_start = '0; e_coin = '0; e_pause = 0;
    end else if (m_valid) begin
      m_phase = ((k_edges / AF) % 2) == 0;
      m_psrc  = 0;
      for (int p = 0; p < NP; p++) begin
        m_dir4 = d_joy[p*JW +: 4] | d_udlr[p*4 +: 4];
        if (p == 0) m_dir4 = m_dir4 | {held[0], held[1], held[2], held[3]};
        e_dir[p*4 +: 4] = m_dir4;
        for (int b = 0; b < NB; b++) begin
          m_r = d_joy[p*JW + 4 + b] | d_btn[p*NB + b] | (p == 0 && held[4 + b]);
          e_btn[p*NB + b] = m_r && (!d_af[b] || m_phase);
        end
        e_start[p] = d_joy[p*JW + 4 + NB] | d_start[p] | (p == 0 && held[7]) | (p == 1 && held[8]);
        m_r = d_joy[p*JW + 5 + NB] | d_coin[p] | (p == 0 && held[9]);
        if (m_r && !prev_coin[p]) since[p] = 0;
        else if (since[p] < 1000) since[p]++;
        prev_coin[p] = m_r;
        e_coin[p] = m_r || (since[p] >= 1 && since[p] <= COIN);
        m_psrc = m_psrc | d_joy[p*JW + 6 + NB] | (p == 0 && held[10]);
      end
      if (d_soft) m_pause = 0;
      else if (m_psrc && !m_pause_prev) m_pause = !m_pause;
      m_pause_prev = m_psrc;
      e_pause = m_pause;

      if (ps2_key[10] != m_tog && tgt(ps2_key[7:0]) >= 0) held[tgt(ps2_key[7:0])] = ps2_key[9];
      m_tog   = ps2_key[10];
      d_joy   = joy_in;   d_udlr = jamma_udlr; d_btn = jamma_btn;
      d_start = jamma_start; d_coin = jamma_coin; d_soft = soft_rst; d_af = autofire_en;
      k_edges++;
    end
  end

  always @(negedge clk) begin
    if (m_valid)
      check("outputs_vs_model", {p_dir, p_btn, start, coin, pause},
            {~e_dir, ~e_btn, ~e_start, ~e_coin, e_pause});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key_event(input logic [7:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    tick();
  endtask

  logic [7:0] codes [14] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29,
                             8'h12, 8'h05, 8'h06, 8'h04, 8'h0C, 8'h1C, 8'h5A};

  initial begin
    int lowcnt, run, maxrun, b1_high;
    rst = 1'b1; ps2_key = '0; joy_in = '0; jamma_udlr = '0; jamma_btn = '0;
    jamma_start = '0; jamma_coin = '0; soft_rst = 1'b0; autofire_en = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_p_dir", p_dir, 8'hFF);
    check("reset_p_btn", p_btn, 4'hF);
    check("reset_start", start, 2'b11);
    check("reset_coin",  coin,  2'b11);
    check("reset_pause", pause, 1'b0);

    key_event(8'h75, 1'b1); tick();
    check("key_up_press", p_dir, 8'hF7);
    key_event(8'h75, 1'b0); tick();
    check("key_up_release", p_dir, 8'hFF);
    key_event(8'h0C, 1'b1); tick();
    check("key_pause_press", pause, 1'b1);
    key_event(8'h0C, 1'b0); tick(); tick();
    check("key_pause_release", pause, 1'b1);

    joy_in[JW-1] = 1'b1; soft_rst = 1'b1; tick();
    soft_rst = 1'b0; tick(); tick();
    check("soft_rst_priority", pause, 1'b0);
    joy_in[JW-1] = 1'b0; repeat (3) tick();

    lowcnt = 0;
    for (int i = 0; i < 20; i++) begin
      jamma_coin[1] = (i == 0);
      tick();
      if (coin[1] == 1'b0) lowcnt++;
    end
    check("coin_single_pulse_len", lowcnt, 11);
    lowcnt = 0;
    for (int i = 0; i < 30; i++) begin
      jamma_coin[1] = (i == 0 || i == 6);
      tick();
      if (coin[1] == 1'b0) lowcnt++;
    end
    check("coin_retrigger_len", lowcnt, 17);

    joy_in[4] = 1'b1; joy_in[5] = 1'b1; autofire_en = 2'b01;
    tick(); tick();
    lowcnt = 0; run = 0; maxrun = 0; b1_high = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (p_btn[0] == 1'b0) begin
        lowcnt++; run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      if (p_btn[1] != 1'b0) b1_high++;
    end
    check("af_low_cycles", lowcnt, 8);
    check("af_low_run", maxrun, 4);
    check("af_off_btn1_held", b1_high, 0);
    joy_in = '0; autofire_en = '0; tick(); tick();

    key_event(8'h14, 1'b1); key_event(8'h11, 1'b0); tick(); tick();
    check("btn0_shared_latch", p_btn, 4'hF);
    key_event(8'h1C, 1'b1); tick(); tick();
    check("unknown_code", {p_dir, p_btn, start, coin, pause}, {8'hFF, 4'hF, 2'b11, 2'b11, 1'b0});

    key_event(8'h75, 1'b1); tick();
    jamma_coin[0] = 1'b1; tick(); jamma_coin[0] = 1'b0; tick(); tick();
    rst = 1'b1; tick();
    check("rst_mid_hold", {p_dir, coin}, {8'hFF, 2'b11});
    rst = 1'b0; tick(); tick();
    check("no_spurious_event", p_dir, 8'hFF);

    repeat (3000) begin
      for (int i = 0; i < NP*JW; i++) joy_in[i] = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NP*4; i++) jamma_udlr[i] = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NP*NB; i++) jamma_btn[i] = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < NP; i++) begin
        jamma_start[i] = ($urandom_range(0, 7) == 0);
        jamma_coin[i]  = ($urandom_range(0, 15) == 0);
      end
      soft_rst = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 49) == 0) autofire_en = NB'($urandom);
      if ($urandom_range(0, 3) == 0)
        ps2_key = {~ps2_key[10], 1'($urandom), 1'($urandom), codes[$urandom_range(0, 13)]};
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
